// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - EX/MEM control bit positions and default payload layout.
package pipe_pkg;

  localparam int CTRL_MEMRD = 4;
  localparam int CTRL_MEMWR = 3;
  localparam int CTRL_BR    = 2;
  localparam int CTRL_M2R   = 1;
  localparam int CTRL_RW    = 0;
  localparam int CTRL_W     = 5;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DEF_DATA_W-1:0] alu_result;
    logic                  zero;
    logic [DEF_DATA_W-1:0] store_data;
    logic [DEF_DATA_W-1:0] branch_target;
    logic [DEF_REG_AW-1:0] write_reg;
  } exmem_payload_t;

endpackage

// File: rtl/skid_buffer_2.sv
// rtl/skid_buffer_2.sv - generic 2-entry skid buffer with synchronous flush.
module skid_buffer_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             consume;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & ~skid_valid;
  assign consume   = main_valid & out_ready;

  // Payload registers only load on a transfer; flush clears valids and leaves data stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (accept && consume) begin
        main_data <= in_data;
      end else if (accept) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end else if (consume) begin
        main_valid <= 1'b0;
      end
    end else if (consume) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX->MEM boundary with valid/ready skid buffering.
// Optional out_pc_src output enabled by EXMEM_BRANCH_RESOLVE_EN.
module ex_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int REG_AW = pipe_pkg::DEF_REG_AW,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_branch_target,
  input  logic [REG_AW-1:0] in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_store_data,
  output logic [DATA_W-1:0] out_branch_target,
  output logic [REG_AW-1:0] out_write_reg
`ifdef EXMEM_BRANCH_RESOLVE_EN
  ,
  output logic              out_pc_src
`endif
);

  localparam int PW = CTRL_W + 3 * DATA_W + 1 + REG_AW;

  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     out_payload;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_payload = {in_ctrl, in_alu_result, in_zero, in_store_data,
                       in_branch_target, in_write_reg};

  skid_buffer_2 #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {main_ctrl, out_alu_result, out_zero, out_store_data,
          out_branch_target, out_write_reg} = out_payload;

  // Gate control so an empty slot never issues a store or register write.
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

`ifdef EXMEM_BRANCH_RESOLVE_EN
  assign out_pc_src = out_valid & out_ctrl[CTRL_BR] & out_zero;
`endif

endmodule
